// File: rtl/fir_sequencer.sv
// Control engine for the FIR datapath: walks samples n and taps k, drives memory reads, MAC control and result writes.
// Optional macro SEQ_CYCLE_CNT_EN adds the 32-bit busy-cycle counter output Cykle.
module fir_sequencer #(
    parameter int RD_LAT = 1,
    parameter int ADR_W  = 14
) (
    input  logic             clk_b,
    input  logic             rst,
    input  logic             Start,
    input  logic [5:0]       Ile_wsp,
    input  logic [ADR_W-1:0] Ile_probek,
    output logic             Pracuje,
    output logic             DONE,
    output logic             rd_en,
    output logic [ADR_W-1:0] adr_probki,
    output logic [5:0]       adr_wsp,
    output logic             mac_clr,
    output logic             mac_en,
    output logic             wr_wyn,
    output logic [ADR_W-1:0] adr_wyn
`ifdef SEQ_CYCLE_CNT_EN
    ,
    output logic [31:0]      Cykle
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ISSUE = 3'd2,
        DRAIN = 3'd3,
        WRITE = 3'd4,
        FIN   = 3'd5
    } state_t;

    localparam logic [2:0] DRAIN_LAST = 3'(RD_LAT - 1);

    state_t           state;
    state_t           state_n;
    logic             start_q;
    logic             start_ev;
    logic [5:0]       wsp_l;
    logic [ADR_W-1:0] prb_l;
    logic [ADR_W-1:0] n;
    logic [ADR_W-1:0] n_inc;
    logic [5:0]       k;
    logic [ADR_W-1:0] k_ext;
    logic             k_last;
    logic [2:0]       drain_cnt;
    logic [RD_LAT-1:0] en_pipe;
    logic [RD_LAT-1:0] clr_pipe;

    // Start/DONE handshake: Start is a level, a run is requested by its 0->1 edge and is only
    // accepted in IDLE or FIN; DONE stays high until the next accepted request clears it.
    assign start_ev = Start & ~start_q;
    assign n_inc    = n + {{(ADR_W-1){1'b0}}, 1'b1};
    assign k_ext    = ADR_W'(k);
    assign k_last   = (k == wsp_l - 6'd1);

    always_ff @(posedge clk_b) begin
        if (rst) begin
            state   <= IDLE;
            start_q <= 1'b0;
        end else begin
            state   <= state_n;
            start_q <= Start;
        end
    end

    always_comb begin
        state_n    = state;
        Pracuje    = 1'b0;
        DONE       = 1'b0;
        rd_en      = 1'b0;
        adr_probki = '0;
        adr_wsp    = '0;
        wr_wyn     = 1'b0;
        adr_wyn    = '0;
        case (state)
            IDLE: begin
                if (start_ev) state_n = LOAD;
            end
            LOAD: begin
                Pracuje = 1'b1;
                // The latched copies are written on this edge, so decide on the live inputs.
                if (Ile_wsp == 6'd0 || Ile_probek == '0) state_n = FIN;
                else                                      state_n = ISSUE;
            end
            ISSUE: begin
                Pracuje    = 1'b1;
                adr_wsp    = k;
                adr_probki = n - k_ext;
                rd_en      = (k_ext <= n);
                if (k_last) state_n = DRAIN;
            end
            DRAIN: begin
                Pracuje = 1'b1;
                if (drain_cnt == DRAIN_LAST) state_n = WRITE;
            end
            WRITE: begin
                Pracuje = 1'b1;
                wr_wyn  = 1'b1;
                adr_wyn = n;
                if (n_inc == prb_l) state_n = FIN;
                else                state_n = ISSUE;
            end
            FIN: begin
                DONE = 1'b1;
                if (start_ev) state_n = LOAD;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_b) begin
        if (rst) begin
            wsp_l     <= '0;
            prb_l     <= '0;
            n         <= '0;
            k         <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                LOAD: begin
                    wsp_l     <= Ile_wsp;
                    prb_l     <= Ile_probek;
                    n         <= '0;
                    k         <= '0;
                    drain_cnt <= '0;
                end
                ISSUE: begin
                    k         <= k_last ? 6'd0 : k + 6'd1;
                    drain_cnt <= '0;
                end
                DRAIN: drain_cnt <= drain_cnt + 3'd1;
                WRITE: n <= n_inc;
                default: ;
            endcase
        end
    end

    // Read strobes ride a RD_LAT-deep pipe so MAC control lines up with returning data.
    always_ff @(posedge clk_b) begin
        if (rst) begin
            en_pipe  <= '0;
            clr_pipe <= '0;
        end else begin
            en_pipe[0]  <= rd_en;
            clr_pipe[0] <= rd_en && (k == 6'd0);
            for (int i = 1; i < RD_LAT; i++) begin
                en_pipe[i]  <= en_pipe[i-1];
                clr_pipe[i] <= clr_pipe[i-1];
            end
        end
    end

    assign mac_en  = en_pipe[RD_LAT-1];
    assign mac_clr = clr_pipe[RD_LAT-1];

`ifdef SEQ_CYCLE_CNT_EN
    // LOAD is itself a busy cycle, so the count restarts at 1 and ends equal to the run length.
    always_ff @(posedge clk_b) begin
        if (rst)                             Cykle <= '0;
        else if (state == LOAD)              Cykle <= 32'd1;
        else if (Pracuje && (Cykle != '1))   Cykle <= Cykle + 32'd1;
    end
`endif

endmodule

// File: tb/tb_fir_sequencer.sv
// Self-checking bench for fir_sequencer: per-cycle expected trace built from the run arithmetic, compared every cycle.
// Build with SEQ_CYCLE_CNT_EN defined to also check Cykle.
module tb_fir_sequencer;
  localparam int RD_LAT = 1;
  localparam int ADR_W  = 14;
  localparam int VW     = 73;
  localparam int P_CY   = 0;
  localparam int P_AY   = 32;
  localparam int P_WR   = 46;
  localparam int P_EN   = 47;
  localparam int P_CLR  = 48;
  localparam int P_AW   = 49;
  localparam int P_AP   = 55;
  localparam int P_RD   = 69;
  localparam int P_DN   = 70;
  localparam int P_PR   = 71;
  localparam int P_ISS  = 72;

  logic             clk_b = 1'b0;
  logic             rst;
  logic             Start;
  logic [5:0]       Ile_wsp;
  logic [ADR_W-1:0] Ile_probek;
  logic             Pracuje, DONE, rd_en, mac_clr, mac_en, wr_wyn;
  logic [ADR_W-1:0] adr_probki, adr_wyn;
  logic [5:0]       adr_wsp;
`ifdef SEQ_CYCLE_CNT_EN
  logic [31:0]      Cykle;
`endif

  fir_sequencer #(.RD_LAT(RD_LAT), .ADR_W(ADR_W)) dut (
    .clk_b(clk_b), .rst(rst), .Start(Start), .Ile_wsp(Ile_wsp), .Ile_probek(Ile_probek),
    .Pracuje(Pracuje), .DONE(DONE), .rd_en(rd_en), .adr_probki(adr_probki), .adr_wsp(adr_wsp),
    .mac_clr(mac_clr), .mac_en(mac_en), .wr_wyn(wr_wyn), .adr_wyn(adr_wyn)
`ifdef SEQ_CYCLE_CNT_EN
    , .Cykle(Cykle)
`endif
  );

  always #5 clk_b = ~clk_b;

  logic [VW-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int obs_busy = 0, obs_en = 0, obs_clr = 0, obs_wr = 0, obs_rd = 0, obs_wr_sum = 0;
  int model_busy;
  bit prev_done = 1'b0;
  int prev_cy = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cyc, act, want);
    end
  endtask

  task automatic compare_cycle();
    logic [VW-1:0] e;
    e = exp_q.pop_front();
    cyc++;
    chk("Pracuje", 32'(Pracuje), 32'(e[P_PR]));
    chk("DONE", 32'(DONE), 32'(e[P_DN]));
    chk("rd_en", 32'(rd_en), 32'(e[P_RD]));
    chk("mac_en", 32'(mac_en), 32'(e[P_EN]));
    chk("mac_clr", 32'(mac_clr), 32'(e[P_CLR]));
    chk("wr_wyn", 32'(wr_wyn), 32'(e[P_WR]));
    if (e[P_ISS]) begin
      chk("adr_probki", 32'(adr_probki), 32'(e[P_AP +: ADR_W]));
      chk("adr_wsp", 32'(adr_wsp), 32'(e[P_AW +: 6]));
    end
    if (e[P_WR]) chk("adr_wyn", 32'(adr_wyn), 32'(e[P_AY +: ADR_W]));
`ifdef SEQ_CYCLE_CNT_EN
    chk("Cykle", Cykle, e[P_CY +: 32]);
`endif
    if (Pracuje === 1'b1) obs_busy++;
    if (mac_en === 1'b1) obs_en++;
    if (mac_clr === 1'b1) obs_clr++;
    if (rd_en === 1'b1) obs_rd++;
    if (wr_wyn === 1'b1) begin
      obs_wr++;
      obs_wr_sum += int'(adr_wyn);
    end
  endtask

  task automatic idle_check(input int cycles);
    logic [VW-1:0] v;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk_b); #1;
      v = '0;
      v[P_DN] = prev_done;
      v[P_CY +: 32] = 32'(prev_cy);
      exp_q.push_back(v);
    end
  endtask

  // One run: two pre-cycles (Start low, then rising), the busy window, three FIN cycles.
  task automatic run(input int w, input int p, input int rst_at, input bit scramble);
    int b, len, base;
    bit did_rst;
    logic [VW-1:0] tr[];
    b = (w == 0 || p == 0) ? 1 : 1 + p * (w + RD_LAT + 1);
    len = 2 + b + 3;
    tr = new[len];
    foreach (tr[i]) tr[i] = '0;
    for (int i = 0; i < 2; i++) begin
      tr[i][P_DN] = prev_done;
      tr[i][P_CY +: 32] = 32'(prev_cy);
    end
    for (int c = 0; c < b; c++) begin
      tr[2+c][P_PR] = 1'b1;
      tr[2+c][P_CY +: 32] = (c == 0) ? 32'(prev_cy) : 32'(c);
    end
    if (b > 1) begin
      for (int n = 0; n < p; n++) begin
        base = 3 + n * (w + RD_LAT + 1);
        for (int j = 0; j < w; j++) begin
          tr[base+j][P_ISS] = 1'b1;
          tr[base+j][P_RD] = (j <= n);
          tr[base+j][P_AW +: 6] = 6'(j);
          tr[base+j][P_AP +: ADR_W] = ADR_W'(n - j);
          if (j <= n) begin
            tr[base+j+RD_LAT][P_EN] = 1'b1;
            if (j == 0) tr[base+j+RD_LAT][P_CLR] = 1'b1;
          end
        end
        tr[base+w+RD_LAT][P_WR] = 1'b1;
        tr[base+w+RD_LAT][P_AY +: ADR_W] = ADR_W'(n);
      end
    end
    for (int i = 2 + b; i < len; i++) begin
      tr[i][P_DN] = 1'b1;
      tr[i][P_CY +: 32] = 32'(b);
    end
    model_busy = 0;
    foreach (tr[i]) if (tr[i][P_PR]) model_busy++;
    if (rst_at >= 0 && rst_at < b) begin
      for (int i = 3 + rst_at; i < len; i++) tr[i] = '0;
    end
    did_rst = 1'b0;
    for (int i = 0; i < len; i++) begin
      @(posedge clk_b); #1;
      if (i == 0) begin
        foreach (tr[t]) exp_q.push_back(tr[t]);
        Start = 1'b0;
      end else if (i == 1) begin
        Start = 1'b1;
        Ile_wsp = 6'(w);
        Ile_probek = ADR_W'(p);
      end else if (did_rst) begin
        rst = 1'b0;
      end else if (rst_at >= 0 && rst_at < b && i == 2 + rst_at) begin
        rst = 1'b1;
        Start = 1'b0;
        did_rst = 1'b1;
      end else if (scramble && i >= 3 && i < 2 + b) begin
        Ile_wsp = 6'($urandom_range(0, 63));
        Ile_probek = ADR_W'($urandom_range(0, 16383));
        Start = 1'($urandom_range(0, 1));
      end
    end
    prev_done = did_rst ? 1'b0 : 1'b1;
    prev_cy = did_rst ? 0 : b;
  endtask

  initial begin
    int s_busy, s_en, s_clr, s_wr, s_rd, s_sum, w, p, r;
    rst = 1'b1;
    Start = 1'b0;
    Ile_wsp = '0;
    Ile_probek = '0;
    fork
      forever begin
        @(negedge clk_b);
        if (exp_q.size() > 0) compare_cycle();
      end
    join_none
    repeat (3) @(posedge clk_b);
    #1 rst = 1'b0;
    idle_check(2);

    // Reference run: 4 taps, 3 samples.
    s_busy = obs_busy; s_en = obs_en; s_clr = obs_clr; s_wr = obs_wr; s_sum = obs_wr_sum;
    run(4, 3, -1, 1'b0);
    chk("model_busy_4x3", 32'(model_busy), 32'd19);
    chk("busy_4x3", 32'(obs_busy - s_busy), 32'd19);
    chk("mac_en_cnt_4x3", 32'(obs_en - s_en), 32'd6);
    chk("mac_clr_cnt_4x3", 32'(obs_clr - s_clr), 32'd3);
    chk("wr_cnt_4x3", 32'(obs_wr - s_wr), 32'd3);
    chk("wr_adr_sum_4x3", 32'(obs_wr_sum - s_sum), 32'd3);

    // Zero taps: one busy cycle, nothing read or written.
    s_busy = obs_busy; s_rd = obs_rd; s_wr = obs_wr;
    run(0, 100, -1, 1'b0);
    chk("busy_w0", 32'(obs_busy - s_busy), 32'd1);
    chk("rd_cnt_w0", 32'(obs_rd - s_rd), 32'd0);
    chk("wr_cnt_w0", 32'(obs_wr - s_wr), 32'd0);

    run(3, 6, -1, 1'b0);
    run(4, 3, -1, 1'b1);
    run(5, 0, -1, 1'b0);
    run(4, 3, 8, 1'b0);
    run(4, 3, -1, 1'b0);
    run(63, 2, -1, 1'b0);

    for (int it = 0; it < 15; it++) begin
      w = $urandom_range(0, 10);
      p = $urandom_range(0, 12);
      r = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : -1;
      run(w, p, r, 1'b1);
    end
    idle_check(3);
    @(posedge clk_b); #1;
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
